// File: rtl/multi_register.sv
// Bank of NUM_REGS independent registers driven by one shared 3-bit operation port,
// with wrap/saturate arithmetic, sticky per-register overflow flags and an address-error pulse.
module multi_register #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            ctrl,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic [NUM_REGS-1:0]   ovf,
    output logic                  zero,
    output logic                  addr_err
);

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_CLR     = 3'd1;
    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_INCR    = 3'd3;
    localparam logic [2:0] OP_DECR    = 3'd4;
    localparam logic [2:0] OP_SHL     = 3'd5;
    localparam logic [2:0] OP_SHR     = 3'd6;
    localparam logic [2:0] OP_CLR_ALL = 3'd7;

    localparam logic [ADDR_WIDTH:0] NREGS_W = NUM_REGS[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   ovf_q;
    logic                  addr_err_q;

    logic [DATA_WIDTH-1:0] cur_val, nxt_val, rd_val;
    logic                  cur_ovf, nxt_ovf;
    logic [DATA_WIDTH:0]   sum, diff;
    logic                  addr_ok, reg_op, do_write;

    assign addr_ok  = ({1'b0, wr_addr} < NREGS_W);
    assign reg_op   = (ctrl != OP_NONE) && (ctrl != OP_CLR_ALL);
    assign do_write = reg_op && addr_ok;

    // Explicit muxes keep out-of-range addresses (NUM_REGS < 2**ADDR_WIDTH) well defined.
    always_comb begin
        cur_val = '0;
        cur_ovf = 1'b0;
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == i[ADDR_WIDTH-1:0]) begin
                cur_val = regs[i];
                cur_ovf = ovf_q[i];
            end
            if (rd_addr == i[ADDR_WIDTH-1:0]) begin
                rd_val = regs[i];
            end
        end
    end

    assign sum  = {1'b0, cur_val} + {1'b0, step};
    assign diff = {1'b0, cur_val} - {1'b0, step};

    always_comb begin
        nxt_val = cur_val;
        nxt_ovf = cur_ovf;
        case (ctrl)
            OP_CLR: begin
                nxt_val = '0;
                nxt_ovf = 1'b0;
            end
            OP_LOAD: begin
                nxt_val = data_input;
                nxt_ovf = 1'b0;
            end
            OP_INCR: begin
                nxt_val = (SATURATE != 0 && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
                nxt_ovf = cur_ovf | sum[DATA_WIDTH];
            end
            OP_DECR: begin
                nxt_val = (SATURATE != 0 && diff[DATA_WIDTH]) ? '0 : diff[DATA_WIDTH-1:0];
                nxt_ovf = cur_ovf | diff[DATA_WIDTH];
            end
            OP_SHL: begin
                nxt_val = {cur_val[DATA_WIDTH-2:0], 1'b0};
                nxt_ovf = cur_ovf | cur_val[DATA_WIDTH-1];
            end
            OP_SHR: begin
                nxt_val = {1'b0, cur_val[DATA_WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            ovf_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= reg_op && !addr_ok;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ctrl == OP_CLR_ALL) begin
                    regs[i]  <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (do_write && wr_addr == i[ADDR_WIDTH-1:0]) begin
                    regs[i]  <= nxt_val;
                    ovf_q[i] <= nxt_ovf;
                end
            end
        end
    end

    assign data_output = rd_val;
    assign zero        = (rd_val == '0);
    assign ovf         = ovf_q;
    assign addr_err    = addr_err_q;

endmodule

// File: doc/multi_register.md
Name: multi_register

Overview:
Parametrised successor of the single control-coded register: a bank of NUM_REGS independent DATA_WIDTH-bit registers sharing one 3-bit operation port.
- Adds variable step increment/decrement, shifts, bank-wide clear, selectable wrap or saturate arithmetic, per-register sticky overflow flags and an address-error pulse.
- Sits in the datapath wherever several counters or pointers were previously instantiated as separate registers.

Parameters:
DATA_WIDTH, 8, width of each register, step and data input (>= 2)
NUM_REGS, 4, number of registers in the bank (1..2**ADDR_WIDTH)
ADDR_WIDTH, 2, width of wr_addr and rd_addr
SATURATE, 0, 0 = INCR/DECR wrap modulo 2**DATA_WIDTH; 1 = clamp at all-ones / zero

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
ctrl  input  3  operation code, applied to register wr_addr
wr_addr  input  ADDR_WIDTH  target register of ctrl
step  input  DATA_WIDTH  unsigned amount for INCR/DECR
data_input  input  DATA_WIDTH  value for LOAD
rd_addr  input  ADDR_WIDTH  register selected onto data_output
data_output  output  DATA_WIDTH  combinational read of register rd_addr (current state)
ovf  output  NUM_REGS  sticky overflow/underflow flag per register
zero  output  1  high when register rd_addr equals 0
addr_err  output  1  one-cycle registered pulse on an invalid wr_addr

Behaviour:
- Reset (rst = 1, asynchronous): all registers 0, ovf all 0, addr_err 0. Therefore data_output = 0 and zero = 1.
- Opcodes, all taking effect at the next rising clk edge on register r = wr_addr:
  - 0 NONE: hold.
  - 1 CLR: r = 0, ovf[r] = 0.
  - 2 LOAD: r = data_input, ovf[r] = 0.
  - 3 INCR: r = r + step.
  - 4 DECR: r = r - step.
  - 5 SHL: r = {r[DATA_WIDTH-2:0], 1'b0}; ovf[r] set if the bit shifted out is 1.
  - 6 SHR: logical shift right by 1; ovf unaffected.
  - 7 CLR_ALL: every register 0, all ovf 0; wr_addr is ignored and never raises addr_err.
- Arithmetic: computed DATA_WIDTH+1 bits wide.
  - INCR carry-out or DECR borrow sets ovf[r].
  - SATURATE=0: result truncated to DATA_WIDTH bits (wrap).
  - SATURATE=1: INCR clamps at all-ones, DECR clamps at 0.
  - step = 0: value unchanged, ovf unchanged.
- ovf is sticky: cleared only by CLR or LOAD of that register, CLR_ALL, or rst. A set and a clear never coincide, because one op targets one register per cycle.
- Only the addressed register changes on ops 1..6; all others hold.
- Invalid address: for ops 1..6 with wr_addr >= NUM_REGS, no register or flag changes and addr_err = 1 for exactly the following cycle. NONE with any wr_addr gives no error.
- Read/write same register in one cycle: data_output and zero show the pre-edge value and update after the edge. No bypass.
- Reset asserted mid-operation overrides any pending op. The first op after deassertion is taken at the first rising edge with rst = 0.
- Latency: one clock from ctrl to register, ovf and addr_err update. Reads and zero are combinational.

Test Plan:
- Reset: assert rst mid-run with regs nonzero and ovf set -> immediately all regs 0, ovf = 0, zero = 1, addr_err = 0.
- Wrap (SATURATE=0, DATA_WIDTH=8): LOAD r1 = 250, INCR step 10 -> r1 = 4, ovf[1] = 1; then DECR step 5 -> r1 = 255, ovf[1] stays 1; LOAD r1 = 7 -> ovf[1] = 0.
- Saturate (SATURATE=1): LOAD r2 = 3, DECR step 5 -> r2 = 0, ovf[2] = 1; LOAD r2 = 250, INCR step 10 -> r2 = 255; other registers unchanged throughout.
- Shifts: LOAD r0 = 8'h81, SHL -> 8'h02, ovf[0] = 1; SHR -> 8'h01; SHR -> 8'h00, zero = 1 with rd_addr = 0.
- Address error (NUM_REGS=3): INCR wr_addr = 3 -> no state change, addr_err high exactly one cycle; CLR_ALL wr_addr = 3 -> all cleared, addr_err stays 0.
- Read-during-write: rd_addr = wr_addr = 1, r1 = 5, INCR step 1 -> data_output = 5 before the edge, 6 after; step = 0 INCR -> value and ovf unchanged.
